uart_rx_8n1: RTL and testbench

UART_RX_8N1 -- requirements
Module: uart_rx_8n1

---
 rtl/uart_rx_8n1.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_8n1.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_8n1.sv
// ---------------------------------------------------------------------------
// uart_rx_8n1 -- 8N1 UART receiver with single-byte holding register.
//
// Receives LSB-first 8N1 frames on ftdi_rx. Each frame is timed from its
// falling start edge. A good frame is presented on rx_byte with rx_valid held
// until acknowledged.
//
// Optional build macro:
//   UART_RX_MAJORITY_EN  - every start/data/stop sample becomes the 2-of-3
//                          majority of the line around the sample point.
//                          When it is undefined, a single line value is used.
//                          Ports and timing are the same in both builds.
//
// Parameters:
//   CLKS_PER_BIT  clk_100mhz cycles per bit time (8..65535)
//
// Ports:
//   clk_100mhz   in   clock, rising edge
//   resetn       in   synchronous active-low reset
//   ftdi_rx      in   asynchronous serial line, idle high
//   rx_ack       in   consumer acknowledge, clears rx_valid
//   rx_byte      out  [7:0] last correctly framed byte
//   rx_valid     out  rx_byte holds an unacknowledged byte
//   framing_err  out  one-cycle pulse when the stop bit is sampled low
//   overrun      out  sticky: a byte completed while rx_valid was high
// ---------------------------------------------------------------------------
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk_100mhz,
    input  logic       resetn,
    input  logic       ftdi_rx,
    input  logic       rx_ack,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       framing_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

`ifdef UART_RX_MAJORITY_EN
    // 2-of-3 vote used to reject a single-cycle spike at a sample point.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    // Synchronizer plus two history stages. line_c_r is the "current" line
    // value the FSM works on; sync2_r is one clock newer and line_m_r one
    // clock older, so the majority window is available without extra delay.
    logic         sync1_r;
    logic         sync2_r;
    logic         line_c_r;
    logic         line_m_r;
    // Fill marker: bit 3 set once every history stage holds a real line
    // sample. Until then the reset value 1 could fake a falling edge.
    logic [3:0]   fill_r;

    state_t           state_r;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shift_r;
    logic [7:0]       shift_n;

    logic         sample_s;
    logic         fall_s;
    logic         byte_done_s;
    logic         frame_err_s;

    logic [7:0]   rx_byte_r;
    logic         rx_valid_r;
    logic         framing_err_r;
    logic         overrun_r;

    // Synchronize ftdi_rx and keep a short history of the synchronized line.
    always_ff @(posedge clk_100mhz) begin
        if (!resetn) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            line_c_r <= 1'b1;
            line_m_r <= 1'b1;
            fill_r   <= 4'b0000;
        end else begin
            sync1_r  <= ftdi_rx;
            sync2_r  <= sync1_r;
            line_c_r <= sync2_r;
            line_m_r <= line_c_r;
            fill_r   <= {fill_r[2:0], 1'b1};
        end
    end

    // Bit sample value and start-edge detect.
    always_comb begin
`ifdef UART_RX_MAJORITY_EN
        sample_s = maj3(line_m_r, line_c_r, sync2_r);
`else
        sample_s = line_c_r;
`endif
        // A genuine high followed by low; gated until the history is real so
        // that a line held low across reset is not mistaken for a start bit.
        fall_s = fill_r[3] & line_m_r & ~line_c_r;
    end

    // FSM state, bit-time counter, bit index and shift register.
    always_ff @(posedge clk_100mhz) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            bit_idx_r <= bit_idx_n;
            shift_r   <= shift_n;
        end
    end

    // Next-state logic; the counter is cleared at every sample point.
    always_comb begin
        state_n     = state_r;
        cnt_n       = CNT_ZERO;
        bit_idx_n   = bit_idx_r;
        shift_n     = shift_r;
        byte_done_s = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bit_idx_n = 3'd0;
                if (fall_s) begin
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_HALF) begin
                    if (!sample_s) begin
                        state_n = ST_DATA;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_END) begin
                    shift_n = {sample_s, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_n = 3'd0;
                        state_n   = ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == CNT_END) begin
                    if (sample_s) begin
                        byte_done_s = 1'b1;
                        state_n     = ST_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_n     = ST_BREAK;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            ST_BREAK: begin
                // Wait out a held-low line; no start detection here.
                if (line_c_r) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_BREAK;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Output holding register, valid/ack handshake and sticky overrun.
    always_ff @(posedge clk_100mhz) begin
        if (!resetn) begin
            rx_byte_r     <= 8'h00;
            rx_valid_r    <= 1'b0;
            framing_err_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            framing_err_r <= frame_err_s;
            if (byte_done_s) begin
                rx_byte_r  <= shift_r;
                rx_valid_r <= 1'b1;
                // An ack in the same cycle consumes the old byte: no overrun.
                if (rx_valid_r && !rx_ack) begin
                    overrun_r <= 1'b1;
                end else begin
                    overrun_r <= overrun_r;
                end
            end else if (rx_valid_r && rx_ack) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    assign rx_byte     = rx_byte_r;
    assign rx_valid    = rx_valid_r;
    assign framing_err = framing_err_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_8n1 -- scoreboard bench for uart_rx_8n1 at CLKS_PER_BIT = 16.
// Stimulus pushes each byte expected to be delivered into exp_q; a monitor
// pops and compares on every rising edge of rx_valid.
// ---------------------------------------------------------------------------
module tb_uart_rx_8n1;

    localparam int CPB = 16;

    logic       clk_100mhz = 1'b0;
    logic       resetn     = 1'b0;
    logic       ftdi_rx    = 1'b1;
    logic       rx_ack     = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk_100mhz  (clk_100mhz),
        .resetn      (resetn),
        .ftdi_rx     (ftdi_rx),
        .rx_ack      (rx_ack),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    bit  ignore_mode = 1'b0;
    int  fe_count    = 0;
    int  fe_long     = 0;
    bit  fe_prev     = 1'b0;
    bit  valid_prev  = 1'b0;
    int  rise_cyc    = 0;
    int  rise_count  = 0;
    int  start_cyc   = 0;
    bit  exp_overrun = 1'b0;

    always @(posedge clk_100mhz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each newly presented byte against the scoreboard.
    always @(negedge clk_100mhz) begin
        if (resetn) begin
            if (framing_err) begin
                if (fe_prev) fe_long++;
                else         fe_count++;
            end
            if (rx_valid && !valid_prev) begin
                rise_cyc = cyc;
                rise_count++;
                if (!ignore_mode) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got %02h, expected no byte", rx_byte);
                    end else begin
                        check("rx_byte", {24'h0, rx_byte}, {24'h0, exp_q.pop_front()});
                    end
                end
            end
        end
        fe_prev    = framing_err;
        valid_prev = rx_valid;
    end

    // Drive one 8N1 frame. spike inverts the line for the one cycle at the
    // centre of every bit; stop_after > 0 abandons the frame after that many cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                              input bit spike, input int stop_after);
        logic [9:0] bits;
        int n;
        bits = {stop_lvl, b, 1'b0};
        n = 0;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                if (stop_after > 0 && n >= stop_after) return;
                @(negedge clk_100mhz);
                if (n == 0) start_cyc = cyc;
                ftdi_rx = (spike && c == 9) ? ~bits[i] : bits[i];
                n++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_100mhz);
    endtask

    task automatic do_ack(input string name);
        @(negedge clk_100mhz);
        rx_ack = 1'b1;
        @(negedge clk_100mhz);
        rx_ack = 1'b0;
        check(name, {31'h0, rx_valid}, 32'h0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_byte"},    {24'h0, rx_byte},     32'h0);
        check({tag, "_valid"},   {31'h0, rx_valid},    32'h0);
        check({tag, "_ferr"},    {31'h0, framing_err}, 32'h0);
        check({tag, "_overrun"}, {31'h0, overrun},     32'h0);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk_100mhz);
            t++;
        end
        check(name, exp_q.size(), 32'h0);
    endtask

    initial begin
        logic [7:0] b;
        int lat;
        int rc;

        // Reset state
        resetn = 1'b0;
        idle(5);
        check_reset_state("reset");
        resetn = 1'b1;
        idle(20);

        // Basic frame and rx_valid latency (about 9.5 bit times plus sync delay)
        exp_q.push_back(8'h35);
        rc = rise_count;
        send_frame(8'h35, 1'b1, 1'b0, 0);
        idle(4);
        check("basic_delivered", rise_count - rc, 1);
        lat = rise_cyc - start_cyc;
        check("latency_window", {31'h0, (lat >= 148 && lat <= 160)}, 32'h1);
        check("basic_ferr", fe_count, 0);
        check("basic_overrun", {31'h0, overrun}, {31'h0, exp_overrun});
        do_ack("basic_ack");

        // Short low glitch: false start, nothing changes
        @(negedge clk_100mhz);
        ftdi_rx = 1'b0;
        idle(4);
        ftdi_rx = 1'b1;
        idle(40);
        check("glitch_valid", {31'h0, rx_valid}, 32'h0);
        check("glitch_byte", {24'h0, rx_byte}, 32'h35);
        check("glitch_ferr", fe_count, 0);
        exp_q.push_back(8'h30);
        send_frame(8'h30, 1'b1, 1'b0, 0);
        idle(4);
        do_ack("glitch_ack");

        // Framing error then held-low break
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        idle(40);
        check("fe_count", fe_count, 1);
        check("fe_pulse_width", fe_long, 0);
        check("fe_valid", {31'h0, rx_valid}, 32'h0);
        check("fe_byte", {24'h0, rx_byte}, 32'h30);
        @(negedge clk_100mhz);
        ftdi_rx = 1'b1;
        idle(20);
        exp_q.push_back(8'h39);
        send_frame(8'h39, 1'b1, 1'b0, 0);
        idle(4);
        do_ack("fe_recover_ack");
        check("pre_overrun", {31'h0, overrun}, {31'h0, exp_overrun});

        // Overrun: two bytes without acknowledge
        exp_q.push_back(8'h31);
        send_frame(8'h31, 1'b1, 1'b0, 0);
        idle(5);
        send_frame(8'h32, 1'b1, 1'b0, 0);
        exp_overrun = 1'b1;
        idle(5);
        check("ovr_byte", {24'h0, rx_byte}, 32'h32);
        check("ovr_valid", {31'h0, rx_valid}, 32'h1);
        check("ovr_flag", {31'h0, overrun}, {31'h0, exp_overrun});
        do_ack("ovr_ack");
        check("ovr_sticky", {31'h0, overrun}, {31'h0, exp_overrun});

        // Random frames with random gaps
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1'b0, 0);
            idle($urandom_range(4, 30));
            do_ack("rand_ack");
        end
        check("rand_overrun_sticky", {31'h0, overrun}, {31'h0, exp_overrun});
        drain("drain_random");

        // Reset in the middle of data bit 3 of 0x55 (line low there)
        send_frame(8'h55, 1'b1, 1'b0, 4 * CPB + 8);
        @(negedge clk_100mhz);
        resetn = 1'b0;
        idle(3);
        check_reset_state("midreset");
        exp_overrun = 1'b0;
        resetn = 1'b1;
        idle(10);
        ftdi_rx = 1'b1;
        idle(40);
        exp_q.push_back(8'h38);
        send_frame(8'h38, 1'b1, 1'b0, 0);
        idle(4);
        check("midreset_byte", {24'h0, rx_byte}, 32'h38);
        do_ack("midreset_ack");
        check("midreset_ferr", fe_count, 1);
        check("midreset_overrun", {31'h0, overrun}, {31'h0, exp_overrun});
        drain("drain_midreset");
        check("fe_never_long", fe_long, 0);

        // One-cycle inverted spike on every sample point
`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1, 0);
        idle(10);
        check("spike_byte", {24'h0, rx_byte}, 32'h5A);
        do_ack("spike_ack");
        drain("drain_spike");
`else
        ignore_mode = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b1, 0);
        idle(300);
        check("spike_corrupts", {31'h0, (rx_byte != 8'h5A)}, 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
